commit_arbiter: RTL and testbench
=================================

COMMIT_ARBITER -- requirements
Module: commit_arbiter

Interface
REQ-001 The block SHALL have parameter FAIR, default 1, meaning 1 = round-robin between ports, 0 = fixed priority to port 0.
REQ-002 The block SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have ports req_valid_i[p]  input  1  commit request from requester p, where p = 0 is ALU/CSR path and p = 1 is load/store unit.
REQ-005 The block SHALL have ports req_ready_o[p]  output  1  request p is accepted this cycle.
REQ-006 The block SHALL have per-port payload inputs pc (32), inst (32), wena (1), waddr (5), wdata (32), csr_wena (1), csr_waddr (32), csr_wdata (32).
REQ-007 The block SHALL have port flush_i  input  1  discard the held commit and block grants this cycle.
REQ-008 The block SHALL have port out_ready_i  input  1  register-file/CSR write port can take the held commit.
REQ-009 The block SHALL have port out_valid_o  output  1  held commit is valid.
REQ-010 The block SHALL have outputs pc_o, inst_o, wena_o, waddr_o, wdata_o, csr_wena_o, csr_waddr_o and csr_wdata_o, each at the widths of REQ-006, carrying the held commit.
REQ-011 The block SHALL have port grant_id_o  output  1  source port of the held commit.
REQ-012 The block SHALL have port retire_cnt_o  output  32  count of commits delivered.

Function
REQ-013 The block SHALL contain a single output holding register with states EMPTY (out_valid_o=0) and FULL (out_valid_o=1).
REQ-014 load_en SHALL be asserted exactly when flush_i=0 and (state EMPTY or out_ready_i=1).
REQ-015 The block SHALL select a winner only when load_en=1 and at least one req_valid_i is set; req_ready_o SHALL be 1 for the winner only, combinationally, and 0 for both ports otherwise.
REQ-016 When FAIR=1 and both ports are valid, the winner SHALL be the port not granted last; the last-grant pointer SHALL update only on an accepted grant. Reset value of the pointer: 1, so port 0 wins first.
REQ-017 When FAIR=0 and both ports are valid, port 0 SHALL always win.
REQ-018 On a grant, the winner's payload SHALL be registered next edge, latency 1, and grant_id_o SHALL equal the winner.
REQ-019 A registered commit with waddr=0 SHALL have wena_o forced to 0; all other fields SHALL pass unchanged.
REQ-020 In FULL with out_ready_i=1 and a grant, the old commit SHALL retire and the new one SHALL load in the same edge, sustaining 1 commit per cycle.
REQ-021 In FULL with out_ready_i=1 and no grant, the next state SHALL be EMPTY.
REQ-022 In FULL with out_ready_i=0, all outputs SHALL hold stable and both req_ready_o SHALL be 0.
REQ-023 retire_cnt_o SHALL increment by 1 on every edge where out_valid_o=1, out_ready_i=1 and flush_i=0, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-024 flush_i=1 SHALL force next state EMPTY, SHALL block all grants and counting that cycle, and SHALL leave the pointer unchanged; the held commit SHALL NOT be counted even if out_ready_i=1.
REQ-025 Requesters SHALL keep valid and payload stable until ready; the block SHALL NOT depend on this for correctness.

Reset
REQ-026 While reset=0, the block SHALL hold state EMPTY, all outputs 0, retire_cnt_o=0, and pointer=1.
REQ-027 Reset assertion mid-operation SHALL drop the held commit immediately without counting it.
REQ-028 The first grant SHALL be possible on the first rising edge after reset=1.

Structure
REQ-029 Shared package commit_pkg SHALL hold the commit payload typedef, the port-index constants PORT_ALU=0 and PORT_LSU=1, and the state encoding EMPTY/FULL.
REQ-030 The winner-select logic and last-grant pointer SHALL live in one sub-module, rr_arbiter2 (inputs: two valids, enable, FAIR; outputs: one-hot grant).

Verification
REQ-031 Both ports valid for 4 cycles with out_ready_i=1 and FAIR=1 -> grant_id_o sequence 0,1,0,1, and retire_cnt_o=4 one cycle after the last commit.
REQ-032 Both ports valid with FAIR=0 -> port 0 granted every cycle, and req_ready_o[1] stays 0.
REQ-033 Port 0 commit with pc=0x80000000 and out_ready_i=0 for 3 cycles -> outputs stable, req_ready_o=0, and a single retire when out_ready_i rises.
REQ-034 Commit with waddr=0, wena=1, wdata=0xDEADBEEF -> wena_o=0 and wdata_o=0xDEADBEEF.
REQ-035 FULL state with flush_i=1 and out_ready_i=1 -> next cycle out_valid_o=0, retire_cnt_o unchanged, and no grant in the flush cycle.
REQ-036 Counter preloaded by running commits to 0xFFFFFFFF, followed by one more commit -> retire_cnt_o=0; reset=0 asserted mid-FULL -> out_valid_o=0 immediately.

Source files
------------

// File: rtl/commit_pkg.sv
// Shared types and constants for the commit arbiter slice.
package commit_pkg;

   // Requester port indices.
   localparam logic PORT_ALU = 1'b0;
   localparam logic PORT_LSU = 1'b1;

   // Output holding register occupancy.
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   // One architectural commit: GPR write plus optional CSR write.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        wena;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        csr_wena;
      logic [31:0] csr_waddr;
      logic [31:0] csr_wdata;
   } commit_t;

   // x0 is hardwired to zero, so a write to it is dropped here.
   function automatic commit_t sanitize_commit(input commit_t c);
      commit_t r;
      r = c;
      if (c.waddr == '0) begin
         r.wena = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester arbiter: round-robin or fixed priority to PORT_ALU.
module rr_arbiter2
   import commit_pkg::*;
#(
   parameter bit FAIR = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] valid,
   input  logic       enable,
   output logic [1:0] grant
);

   // Port granted most recently; resets to LSU so ALU wins first.
   logic last_q;

   // One-hot winner selection, only while the holding register can load.
   always_comb begin
      grant = '0;
      if (enable) begin
         if (valid[PORT_ALU] && valid[PORT_LSU]) begin
            if (FAIR && (last_q == PORT_ALU)) begin
               grant[PORT_LSU] = 1'b1;
            end else begin
               grant[PORT_ALU] = 1'b1;
            end
         end else begin
            grant = valid;
         end
      end
   end

   // Last-grant pointer moves only when a grant is actually issued.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_q <= PORT_LSU;
      end else if (|grant) begin
         last_q <= grant[PORT_LSU];
      end
   end

endmodule

// File: rtl/commit_arbiter.sv
// Merges ALU/CSR and LSU commit streams into one registered write port.
module commit_arbiter
   import commit_pkg::*;
#(
   parameter bit FAIR = 1'b1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [1:0]      req_valid_i,
   output logic [1:0]      req_ready_o,
   input  logic [1:0][31:0] pc_i,
   input  logic [1:0][31:0] inst_i,
   input  logic [1:0]      wena_i,
   input  logic [1:0][4:0] waddr_i,
   input  logic [1:0][31:0] wdata_i,
   input  logic [1:0]      csr_wena_i,
   input  logic [1:0][31:0] csr_waddr_i,
   input  logic [1:0][31:0] csr_wdata_i,
   input  logic            flush_i,
   input  logic            out_ready_i,
   output logic            out_valid_o,
   output logic [31:0]     pc_o,
   output logic [31:0]     inst_o,
   output logic            wena_o,
   output logic [4:0]      waddr_o,
   output logic [31:0]     wdata_o,
   output logic            csr_wena_o,
   output logic [31:0]     csr_waddr_o,
   output logic [31:0]     csr_wdata_o,
   output logic            grant_id_o,
   output logic [31:0]     retire_cnt_o
);

   state_e      state_q;
   commit_t     hold_q;
   commit_t     sel;
   logic        gid_q;
   logic [31:0] retire_cnt_q;
   logic        load_en;
   logic        retire;
   logic [1:0]  grant;
   logic        src;

   // Holding register may take a new commit when empty or draining this edge.
   always_comb begin
      load_en = !flush_i && ((state_q == EMPTY) || out_ready_i);
      retire  = (state_q == FULL) && out_ready_i && !flush_i;
   end

   rr_arbiter2 #(
      .FAIR (FAIR)
   ) u_arb (
      .clock  (clock),
      .reset  (reset),
      .valid  (req_valid_i),
      .enable (load_en),
      .grant  (grant)
   );

   // Mux the winner's payload into a single commit record.
   always_comb begin
      src           = grant[PORT_LSU];
      sel           = '0;
      sel.pc        = pc_i[src];
      sel.inst      = inst_i[src];
      sel.wena      = wena_i[src];
      sel.waddr     = waddr_i[src];
      sel.wdata     = wdata_i[src];
      sel.csr_wena  = csr_wena_i[src];
      sel.csr_waddr = csr_waddr_i[src];
      sel.csr_wdata = csr_wdata_i[src];
   end

   // Occupancy FSM and payload register; load takes precedence over drain.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= EMPTY;
         hold_q  <= '0;
         gid_q   <= 1'b0;
      end else if (flush_i) begin
         state_q <= EMPTY;
      end else if (|grant) begin
         state_q <= FULL;
         hold_q  <= sanitize_commit(sel);
         gid_q   <= src;
      end else if (retire) begin
         state_q <= EMPTY;
      end
   end

   // Count delivered commits; wraps naturally at 32 bits.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         retire_cnt_q <= '0;
      end else if (retire) begin
         retire_cnt_q <= retire_cnt_q + 32'd1;
      end
   end

   assign req_ready_o  = grant;
   assign out_valid_o  = (state_q == FULL);
   assign pc_o         = hold_q.pc;
   assign inst_o       = hold_q.inst;
   assign wena_o       = hold_q.wena;
   assign waddr_o      = hold_q.waddr;
   assign wdata_o      = hold_q.wdata;
   assign csr_wena_o   = hold_q.csr_wena;
   assign csr_waddr_o  = hold_q.csr_waddr;
   assign csr_wdata_o  = hold_q.csr_wdata;
   assign grant_id_o   = gid_q;
   assign retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_commit_arbiter.sv
// Directed self-checking bench for commit_arbiter (FAIR=1 and FAIR=0 instances).
module tb_commit_arbiter;

   logic             clock;
   logic             reset;
   logic [1:0]       req_valid_i;
   logic [1:0][31:0] pc_i;
   logic [1:0][31:0] inst_i;
   logic [1:0]       wena_i;
   logic [1:0][4:0]  waddr_i;
   logic [1:0][31:0] wdata_i;
   logic [1:0]       csr_wena_i;
   logic [1:0][31:0] csr_waddr_i;
   logic [1:0][31:0] csr_wdata_i;
   logic             flush_i;
   logic             out_ready_i;

   logic [1:0]  req_ready_o,  req_ready_fp;
   logic        out_valid_o,  out_valid_fp;
   logic [31:0] pc_o,         pc_fp;
   logic [31:0] inst_o,       inst_fp;
   logic        wena_o,       wena_fp;
   logic [4:0]  waddr_o,      waddr_fp;
   logic [31:0] wdata_o,      wdata_fp;
   logic        csr_wena_o,   csr_wena_fp;
   logic [31:0] csr_waddr_o,  csr_waddr_fp;
   logic [31:0] csr_wdata_o,  csr_wdata_fp;
   logic        grant_id_o,   grant_id_fp;
   logic [31:0] retire_cnt_o, retire_cnt_fp;

   int checks = 0;
   int errors = 0;

   commit_arbiter #(.FAIR(1'b1)) dut (
      .clock(clock), .reset(reset),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .pc_i(pc_i), .inst_i(inst_i), .wena_i(wena_i), .waddr_i(waddr_i),
      .wdata_i(wdata_i), .csr_wena_i(csr_wena_i), .csr_waddr_i(csr_waddr_i),
      .csr_wdata_i(csr_wdata_i), .flush_i(flush_i), .out_ready_i(out_ready_i),
      .out_valid_o(out_valid_o), .pc_o(pc_o), .inst_o(inst_o), .wena_o(wena_o),
      .waddr_o(waddr_o), .wdata_o(wdata_o), .csr_wena_o(csr_wena_o),
      .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
      .grant_id_o(grant_id_o), .retire_cnt_o(retire_cnt_o)
   );

   commit_arbiter #(.FAIR(1'b0)) dut_fp (
      .clock(clock), .reset(reset),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_fp),
      .pc_i(pc_i), .inst_i(inst_i), .wena_i(wena_i), .waddr_i(waddr_i),
      .wdata_i(wdata_i), .csr_wena_i(csr_wena_i), .csr_waddr_i(csr_waddr_i),
      .csr_wdata_i(csr_wdata_i), .flush_i(flush_i), .out_ready_i(out_ready_i),
      .out_valid_o(out_valid_fp), .pc_o(pc_fp), .inst_o(inst_fp), .wena_o(wena_fp),
      .waddr_o(waddr_fp), .wdata_o(wdata_fp), .csr_wena_o(csr_wena_fp),
      .csr_waddr_o(csr_waddr_fp), .csr_wdata_o(csr_wdata_fp),
      .grant_id_o(grant_id_fp), .retire_cnt_o(retire_cnt_fp)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_port(input bit p, input logic [31:0] pc, input logic [4:0] waddr,
                           input logic wena, input logic [31:0] wdata);
      pc_i[p]        = pc;
      inst_i[p]      = ~pc;
      waddr_i[p]     = waddr;
      wena_i[p]      = wena;
      wdata_i[p]     = wdata;
      csr_wena_i[p]  = wena;
      csr_waddr_i[p] = pc + 32'd4;
      csr_wdata_i[p] = wdata ^ 32'hFFFF0000;
   endtask

   initial begin
      reset       = 1'b0;
      req_valid_i = '0;
      flush_i     = 1'b0;
      out_ready_i = 1'b0;
      set_port(1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
      set_port(1'b1, 32'h0, 5'd0, 1'b0, 32'h0);

      // Reset state
      step();
      step();
      check("rst_valid",   32'(out_valid_o), 32'd0);
      check("rst_cnt",     retire_cnt_o, 32'd0);
      check("rst_ready",   32'(req_ready_o), 32'd0);
      check("rst_gid",     32'(grant_id_o), 32'd0);
      check("rst_pc",      pc_o, 32'd0);

      // Round-robin burst: both valid, sink always ready
      @(negedge clock);
      reset = 1'b1;
      set_port(1'b0, 32'h0000_0100, 5'd1, 1'b1, 32'h1111_0000);
      set_port(1'b1, 32'h0000_0200, 5'd2, 1'b1, 32'h2222_0000);
      req_valid_i = 2'b11;
      out_ready_i = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         check("rr_ready",    32'(req_ready_o), (k % 2 == 0) ? 32'd1 : 32'd2);
         check("fp_ready",    32'(req_ready_fp), 32'd1);
         step();
         check("rr_valid",    32'(out_valid_o), 32'd1);
         check("rr_gid",      32'(grant_id_o), 32'(k % 2));
         check("rr_pc",       pc_o, (k % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
         check("rr_cnt",      retire_cnt_o, 32'(k));
         check("fp_gid",      32'(grant_id_fp), 32'd0);
         check("fp_pc",       pc_fp, 32'h0000_0100);
         check("fp_cnt",      retire_cnt_fp, 32'(k));
      end
      check("rr_inst",     inst_o, ~32'h0000_0200);
      check("rr_csr_addr", csr_waddr_o, 32'h0000_0204);
      check("rr_csr_data", csr_wdata_o, 32'hDDDD_0000);
      req_valid_i = 2'b00;
      step();
      check("rr_drain_valid", 32'(out_valid_o), 32'd0);
      check("rr_cnt4",        retire_cnt_o, 32'd4);
      check("fp_cnt4",        retire_cnt_fp, 32'd4);

      // Backpressure: hold a commit for three cycles
      set_port(1'b0, 32'h8000_0000, 5'd3, 1'b1, 32'h0000_0033);
      req_valid_i = 2'b01;
      out_ready_i = 1'b0;
      #1;
      check("bp_ready_load", 32'(req_ready_o), 32'd1);
      step();
      check("bp_valid", 32'(out_valid_o), 32'd1);
      check("bp_pc",    pc_o, 32'h8000_0000);
      set_port(1'b0, 32'h8000_1000, 5'd4, 1'b1, 32'h0000_0044);
      req_valid_i = 2'b11;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_ready_held", 32'(req_ready_o), 32'd0);
         check("bp_fp_ready",   32'(req_ready_fp), 32'd0);
         step();
         check("bp_valid_held", 32'(out_valid_o), 32'd1);
         check("bp_pc_held",    pc_o, 32'h8000_0000);
         check("bp_wdata_held", wdata_o, 32'h0000_0033);
         check("bp_cnt_held",   retire_cnt_o, 32'd4);
      end
      req_valid_i = 2'b00;
      out_ready_i = 1'b1;
      step();
      check("bp_retire_cnt",   retire_cnt_o, 32'd5);
      check("bp_retire_valid", 32'(out_valid_o), 32'd0);
      step();
      check("bp_single_retire", retire_cnt_o, 32'd5);

      // Writes to x0 are suppressed, data passes through
      set_port(1'b1, 32'h0000_0400, 5'd0, 1'b1, 32'hDEAD_BEEF);
      req_valid_i = 2'b10;
      #1;
      check("x0_ready", 32'(req_ready_o), 32'd2);
      step();
      check("x0_wena",  32'(wena_o), 32'd0);
      check("x0_wdata", wdata_o, 32'hDEAD_BEEF);
      check("x0_waddr", 32'(waddr_o), 32'd0);
      check("x0_gid",   32'(grant_id_o), 32'd1);
      check("x0_csr_wena", 32'(csr_wena_o), 32'd1);
      set_port(1'b1, 32'h0000_0500, 5'd5, 1'b1, 32'h0000_0055);
      step();
      check("x5_wena", 32'(wena_o), 32'd1);
      check("x5_waddr", 32'(waddr_o), 32'd5);
      check("x5_cnt",  retire_cnt_o, 32'd6);
      req_valid_i = 2'b00;
      step();
      check("x5_drain_cnt", retire_cnt_o, 32'd7);

      // Flush while FULL with sink ready
      set_port(1'b0, 32'h0000_0300, 5'd6, 1'b1, 32'h0000_0066);
      req_valid_i = 2'b01;
      step();
      check("fl_loaded", 32'(out_valid_o), 32'd1);
      flush_i     = 1'b1;
      req_valid_i = 2'b11;
      #1;
      check("fl_no_grant", 32'(req_ready_o), 32'd0);
      step();
      check("fl_valid", 32'(out_valid_o), 32'd0);
      check("fl_cnt",   retire_cnt_o, 32'd7);
      flush_i = 1'b0;
      #1;
      check("fl_ptr_kept", 32'(req_ready_o), 32'd2);
      step();
      check("fl_gid", 32'(grant_id_o), 32'd1);
      req_valid_i = 2'b00;
      step();
      check("fl_drain_cnt", retire_cnt_o, 32'd8);

      // Counter wrap from all-ones
      @(negedge clock);
      force dut.retire_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.retire_cnt_q;
      #1;
      check("wr_preload", retire_cnt_o, 32'hFFFF_FFFF);
      req_valid_i = 2'b01;
      step();
      check("wr_pre_cnt", retire_cnt_o, 32'hFFFF_FFFF);
      req_valid_i = 2'b00;
      step();
      check("wr_wrapped", retire_cnt_o, 32'd0);

      // Asynchronous reset mid-FULL
      req_valid_i = 2'b01;
      out_ready_i = 1'b0;
      step();
      check("ar_full", 32'(out_valid_o), 32'd1);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("ar_valid", 32'(out_valid_o), 32'd0);
      check("ar_cnt",   retire_cnt_o, 32'd0);
      check("ar_pc",    pc_o, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
